zet_shrot_seq: RTL and testbench
================================

ZET_SHROT_SEQ -- requirements
Module: zet_shrot_seq

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 x  input  16  operand; byte ops use x[7:0].
REQ-006 cnt  input  5  shift/rotate count.
REQ-007 func  input  3  op code: ROL, ROR, RCL, RCR, SHL, SHR, SAR (one value unused).
REQ-008 word_op  input  1  1 = 16-bit, 0 = 8-bit.
REQ-009 cfi, ofi  input  1 each  incoming CF/OF, returned unchanged when cnt=0.
REQ-010 o  output  16  result; byte ops drive o[15:8]=8'h00.
REQ-011 cfo, ofo  output  1 each  carry/overflow flags.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 done  output  1  one-cycle pulse: o/cfo/ofo valid.

Function
REQ-014 SHALL capture x, cnt, func, word_op, cfi, ofi on the edge that samples start in IDLE.
REQ-015 SHALL use FSM states IDLE, RUN, DONE: IDLE->RUN on start with cnt!=0; IDLE->DONE on start with cnt=0; RUN->DONE when the remaining count reaches 0; DONE->IDLE unconditionally.
REQ-016 SHALL perform exactly one single-bit step per RUN cycle, so done is high in the cycle after cnt+1 edges from the sampling edge; at most one operation is in flight.
REQ-017 SHALL ignore start while busy or done is high, with no effect on the operation in flight.
REQ-018 busy SHALL be high in RUN and DONE; done SHALL be high only in DONE.
REQ-019 o, cfo, ofo SHALL hold their values from DONE until the next start is accepted.
REQ-020 Each step: CF = bit shifted out.
  - ROL/ROR: bit shifted out is rotated back in.
  - RCL/RCR: rotate through CF.
  - SHL/SHR: insert 0.
  - SAR: replicate the sign bit (bit 15 word, bit 7 byte).
REQ-021 For cnt!=0, ofo SHALL be computed once, after the final step:
  - ROL/RCL/SHL: result MSB XOR cfo.
  - ROR/RCR: result MSB XOR result MSB-1.
  - SHR: original operand MSB.
  - SAR: 0.
REQ-022 For cnt=0: o = x (byte: upper byte zeroed), cfo = cfi, ofo = ofi.
REQ-023 cnt is the full 5-bit count, not reduced modulo width; counts ≥ width SHALL be stepped literally (e.g. SHL word cnt=20 yields 0).
REQ-024 The unused func code SHALL behave as cnt=0 (pass-through) but still pass through DONE.

Reset
REQ-025 On rst, state SHALL go to IDLE and o, cfo, ofo, busy, done SHALL be 0, including during RUN/DONE.
REQ-026 start SHALL be ignored in any cycle where rst is high.

Structure
REQ-027 The func code constants and FSM state encodings SHALL live in a shared zet_shrot_defs package/include, also used by the ALU decode.
REQ-028 The single-bit step SHALL be a combinational sub-module, zet_shrot_step (inputs: value, CF, func, word_op; outputs: next value, next CF).
REQ-029 The block SHALL use a 5-bit down-counter and no multipliers or barrel shifter.

Verification
REQ-030 Word ROL, x=16'h8001, cnt=1 -> done 2 edges after start; o=16'h0003, cfo=1, ofo=1.
REQ-031 Byte RCR, x=16'hAB01, cfi=0, cnt=2 -> o=16'h0080, cfo=0, ofo=1, done 3 edges after start.
REQ-032 Word SAR, x=16'h8000, cnt=15 -> o=16'hFFFF, cfo=0, ofo=0, busy high 16 cycles.
REQ-033 Word SHL, x=16'h1234, cnt=0, cfi=1, ofi=1 -> done next cycle; o=16'h1234, cfo=1, ofo=1.
REQ-034 Word SHL, x=16'h0001, cnt=20, second start issued while busy -> only first op completes; o=0, cfo=0.
REQ-035 Same as REQ-034 with rst asserted on the 5th RUN cycle -> next edge all outputs 0, IDLE; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/zet_shrot_defs.sv
// Shared definitions for the sequential shift/rotate unit: operation codes,
// controller states and a small decode helper used by the step logic.
package zet_shrot_defs;

    // Operation codes follow the classic x86 group-2 ordering; code 6 is unused
    // and treated as a pass-through.
    typedef enum logic [2:0] {
        FN_ROL = 3'd0,
        FN_ROR = 3'd1,
        FN_RCL = 3'd2,
        FN_RCR = 3'd3,
        FN_SHL = 3'd4,
        FN_SHR = 3'd5,
        FN_NOP = 3'd6,
        FN_SAR = 3'd7
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for the operations that move bits towards the MSB.
    function automatic logic isLeft(input logic [2:0] f);
        return (f == FN_ROL) || (f == FN_RCL) || (f == FN_SHL);
    endfunction

endpackage

// File: rtl/zet_shrot_step.sv
// One single-bit shift/rotate step on an 8- or 16-bit value, purely combinational.
// Byte operations live in bits [7:0] and always leave the upper byte zero.
module zet_shrot_step
    import zet_shrot_defs::*;
(
    input  logic [15:0] i_value,
    input  logic        i_cf,
    input  logic [2:0]  i_func,
    input  logic        i_wordOp,
    output logic [15:0] o_value,
    output logic        o_cf
);

    logic w_msb;
    logic w_inBit;

    assign w_msb = i_wordOp ? i_value[15] : i_value[7];

    // Pick the bit that enters the vacated position for this operation.
    always_comb begin
        w_inBit = 1'b0;
        case (i_func)
            FN_ROL, FN_SAR: w_inBit = w_msb;
            FN_ROR:         w_inBit = i_value[0];
            FN_RCL, FN_RCR: w_inBit = i_cf;
            default:        w_inBit = 1'b0;
        endcase
    end

    // Move the value one position and report the bit that fell off as the new CF.
    always_comb begin
        o_value = i_value;
        o_cf    = i_cf;
        if (i_func == FN_NOP) begin
            o_value = i_value;
            o_cf    = i_cf;
        end else if (isLeft(i_func)) begin
            o_value = i_wordOp ? {i_value[14:0], w_inBit}
                               : {8'h00, i_value[6:0], w_inBit};
            o_cf    = w_msb;
        end else begin
            o_value = i_wordOp ? {w_inBit, i_value[15:1]}
                               : {8'h00, w_inBit, i_value[7:1]};
            o_cf    = i_value[0];
        end
    end

endmodule

// File: rtl/zet_shrot_seq.sv
// Sequential shift/rotate unit: performs one bit step per clock, counting the
// full 5-bit count down, and presents result and flags with a one-cycle done pulse.
module zet_shrot_seq
    import zet_shrot_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    input  logic [4:0]  cnt,
    input  logic [2:0]  func,
    input  logic        word_op,
    input  logic        cfi,
    input  logic        ofi,
    output logic [15:0] o,
    output logic        cfo,
    output logic        ofo,
    output logic        busy,
    output logic        done
);

    state_e      r_state;
    state_e      w_nextState;
    logic [15:0] r_val;
    logic        r_cf;
    logic [4:0]  r_count;
    logic [2:0]  r_func;
    logic        r_wordOp;
    logic        r_origMsb;
    logic [15:0] r_o;
    logic        r_cfo;
    logic        r_ofo;

    logic [15:0] w_stepVal;
    logic        w_stepCf;
    logic [15:0] w_maskedX;
    logic        w_passThru;
    logic        w_lastStep;
    logic        w_resMsb;
    logic        w_resMsb1;
    logic        w_finalOf;

    zet_shrot_step u_step (
        .i_value  (r_val),
        .i_cf     (r_cf),
        .i_func   (r_func),
        .i_wordOp (r_wordOp),
        .o_value  (w_stepVal),
        .o_cf     (w_stepCf)
    );

    assign w_maskedX  = word_op ? x : {8'h00, x[7:0]};
    assign w_passThru = (cnt == 5'd0) || (func == FN_NOP);
    assign w_lastStep = (r_count == 5'd1);
    assign w_resMsb   = r_wordOp ? w_stepVal[15] : w_stepVal[7];
    assign w_resMsb1  = r_wordOp ? w_stepVal[14] : w_stepVal[6];

    // Overflow is only meaningful after the final step, derived from the final result.
    always_comb begin
        w_finalOf = 1'b0;
        case (r_func)
            FN_ROL, FN_RCL, FN_SHL: w_finalOf = w_resMsb ^ w_stepCf;
            FN_ROR, FN_RCR:         w_finalOf = w_resMsb ^ w_resMsb1;
            FN_SHR:                 w_finalOf = r_origMsb;
            default:                w_finalOf = 1'b0;
        endcase
    end

    // Controller next state: zero counts and the unused code go straight to DONE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (start) w_nextState = w_passThru ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_lastStep) w_nextState = ST_DONE;
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nextState;
    end

    // Operand capture, per-cycle stepping and result latching; results hold until the next DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val     <= 16'h0000;
            r_cf      <= 1'b0;
            r_count   <= 5'd0;
            r_func    <= 3'd0;
            r_wordOp  <= 1'b0;
            r_origMsb <= 1'b0;
            r_o       <= 16'h0000;
            r_cfo     <= 1'b0;
            r_ofo     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_val     <= w_maskedX;
                        r_cf      <= cfi;
                        r_count   <= cnt;
                        r_func    <= func;
                        r_wordOp  <= word_op;
                        r_origMsb <= word_op ? x[15] : x[7];
                        if (w_passThru) begin
                            r_o   <= w_maskedX;
                            r_cfo <= cfi;
                            r_ofo <= ofi;
                        end
                    end
                end
                ST_RUN: begin
                    r_val   <= w_stepVal;
                    r_cf    <= w_stepCf;
                    r_count <= r_count - 5'd1;
                    if (w_lastStep) begin
                        r_o   <= w_stepVal;
                        r_cfo <= w_stepCf;
                        r_ofo <= w_finalOf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o    = r_o;
    assign cfo  = r_cfo;
    assign ofo  = r_ofo;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_zet_shrot_seq.sv
// Self-checking bench for zet_shrot_seq: a behavioural reference model tracks the
// expected outputs every cycle, and directed operations pin results with literals.
module tb_zet_shrot_seq;

    localparam logic [2:0] OP_ROL = 3'd0;
    localparam logic [2:0] OP_ROR = 3'd1;
    localparam logic [2:0] OP_RCL = 3'd2;
    localparam logic [2:0] OP_RCR = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_UNU = 3'd6;
    localparam logic [2:0] OP_SAR = 3'd7;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [4:0]  cnt;
    logic [2:0]  func;
    logic        word_op;
    logic        cfi;
    logic        ofi;
    logic [15:0] o;
    logic        cfo;
    logic        ofo;
    logic        busy;
    logic        done;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model state: cycles of busy remaining and the expected outputs.
    int          mLeft = 0;
    logic [15:0] mO    = 16'h0000;
    logic        mCf   = 1'b0;
    logic        mOf   = 1'b0;
    logic [17:0] mPend = 18'h0;

    zet_shrot_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .cnt     (cnt),
        .func    (func),
        .word_op (word_op),
        .cfi     (cfi),
        .ofi     (ofi),
        .o       (o),
        .cfo     (cfo),
        .ofo     (ofo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of a whole operation computed with integer arithmetic: {o, cfo, ofo}.
    function automatic logic [17:0] modelOp(input logic [2:0] f, input logic w,
                                            input logic [15:0] xin, input logic [4:0] n,
                                            input logic ci, input logic oi);
        int width = w ? 16 : 8;
        int mask  = (1 << width) - 1;
        int v     = int'(xin) & mask;
        int c     = int'(ci);
        int orig  = (v >> (width - 1)) & 1;
        int top;
        int bot;
        int nxt;
        int ov;
        if (n == 5'd0 || f == OP_UNU) return {16'(v), ci, oi};
        for (int k = 0; k < int'(n); k++) begin
            top = (v >> (width - 1)) & 1;
            bot = v & 1;
            case (f)
                OP_ROL: begin c = top; v = ((v << 1) | top) & mask; end
                OP_ROR: begin c = bot; v = (v >> 1) | (bot << (width - 1)); end
                OP_RCL: begin v = ((v << 1) | c) & mask; c = top; end
                OP_RCR: begin v = (v >> 1) | (c << (width - 1)); c = bot; end
                OP_SHL: begin c = top; v = (v << 1) & mask; end
                OP_SHR: begin c = bot; v = v >> 1; end
                default: begin c = bot; v = (v >> 1) | (top << (width - 1)); end
            endcase
        end
        top = (v >> (width - 1)) & 1;
        nxt = (v >> (width - 2)) & 1;
        case (f)
            OP_ROL, OP_RCL, OP_SHL: ov = top ^ c;
            OP_ROR, OP_RCR:         ov = top ^ nxt;
            OP_SHR:                 ov = orig;
            default:                ov = 0;
        endcase
        return {16'(v), 1'(c), 1'(ov)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model update on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (rst) begin
            mLeft = 0;
            mO    = 16'h0000;
            mCf   = 1'b0;
            mOf   = 1'b0;
        end else if (mLeft == 0) begin
            if (start) begin
                mPend = modelOp(func, word_op, x, cnt, cfi, ofi);
                mLeft = (cnt == 5'd0 || func == OP_UNU) ? 1 : int'(cnt) + 1;
            end
        end else begin
            mLeft--;
        end
        if (mLeft == 1) begin
            mO  = mPend[17:2];
            mCf = mPend[1];
            mOf = mPend[0];
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clk) begin
        checkOutput("busy", 32'(busy), 32'(mLeft != 0));
        checkOutput("done", 32'(done), 32'(mLeft == 1));
        if (mLeft <= 1) begin
            checkOutput("o",   32'(o),   32'(mO));
            checkOutput("cfo", 32'(cfo), 32'(mCf));
            checkOutput("ofo", 32'(ofo), 32'(mOf));
        end
    end

    // Issue one operation, optionally a second start while busy, and check literals.
    task automatic applyStimulus(input string name, input logic [2:0] f, input logic w,
                                 input logic [15:0] xin, input logic [4:0] n,
                                 input logic ci, input logic oi,
                                 input logic [15:0] expO, input logic expCf, input logic expOf,
                                 input int expEdges, input int secondAt);
        int          doneEdge = 0;
        int          busyCnt  = 0;
        logic [15:0] gotO     = 16'h0;
        logic        gotCf    = 1'b0;
        logic        gotOf    = 1'b0;
        logic [17:0] mr;
        mr = modelOp(f, w, xin, n, ci, oi);
        checkOutput({name, " model"}, 32'(mr), 32'({expO, expCf, expOf}));
        @(negedge clk);
        func = f; word_op = w; x = xin; cnt = n; cfi = ci; ofi = oi;
        start = 1'b1;
        for (int e = 1; e <= 64; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) start = 1'b0;
            if (secondAt != 0 && e == secondAt + 1) start = 1'b0;
            if (secondAt != 0 && e == secondAt) begin
                start = 1'b1; x = 16'hFFFF; func = OP_ROR; cnt = 5'd3; word_op = 1'b1;
            end
            if (busy) busyCnt++;
            if (done && doneEdge == 0) begin
                doneEdge = e;
                gotO = o; gotCf = cfo; gotOf = ofo;
            end
            if (!busy && doneEdge != 0) break;
        end
        start = 1'b0;
        checkOutput({name, " doneEdge"}, 32'(doneEdge), 32'(expEdges));
        checkOutput({name, " busyCycles"}, 32'(busyCnt), 32'(expEdges));
        checkOutput({name, " o"}, 32'(gotO), 32'(expO));
        checkOutput({name, " cfo"}, 32'(gotCf), 32'(expCf));
        checkOutput({name, " ofo"}, 32'(gotOf), 32'(expOf));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; x = 16'h0; cnt = 5'd0; func = 3'd0;
        word_op = 1'b1; cfi = 1'b0; ofi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset o", 32'(o), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("ROL w",   OP_ROL, 1'b1, 16'h8001, 5'd1,  1'b0, 1'b0, 16'h0003, 1'b1, 1'b1, 2, 0);
        applyStimulus("RCR b",   OP_RCR, 1'b0, 16'hAB01, 5'd2,  1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 3, 0);
        applyStimulus("SAR w",   OP_SAR, 1'b1, 16'h8000, 5'd15, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16, 0);
        applyStimulus("SHL w0",  OP_SHL, 1'b1, 16'h1234, 5'd0,  1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1, 0);
        applyStimulus("SHL w20", OP_SHL, 1'b1, 16'h0001, 5'd20, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 21, 3);
        applyStimulus("ROR w",   OP_ROR, 1'b1, 16'h0001, 5'd1,  1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 2, 0);
        applyStimulus("SHL b",   OP_SHL, 1'b0, 16'hFF81, 5'd1,  1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 2, 0);
        applyStimulus("RCL w",   OP_RCL, 1'b1, 16'h8000, 5'd2,  1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 3, 0);
        applyStimulus("unused",  OP_UNU, 1'b1, 16'hABCD, 5'd5,  1'b0, 1'b1, 16'hABCD, 1'b0, 1'b1, 1, 0);
        applyStimulus("SAR b9",  OP_SAR, 1'b0, 16'h0080, 5'd9,  1'b0, 1'b0, 16'h00FF, 1'b1, 1'b0, 10, 0);
        applyStimulus("SHR b",   OP_SHR, 1'b0, 16'h1280, 5'd1,  1'b0, 1'b0, 16'h0040, 1'b0, 1'b1, 2, 0);

        // Reset in the middle of a long operation, on its fifth RUN cycle.
        @(negedge clk);
        func = OP_SHL; word_op = 1'b1; x = 16'h0001; cnt = 5'd20; cfi = 1'b0; ofi = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst o", 32'(o), 32'h0);
        checkOutput("midrst cfo", 32'(cfo), 32'h0);
        checkOutput("midrst ofo", 32'(ofo), 32'h0);
        checkOutput("midrst busy", 32'(busy), 32'h0);
        checkOutput("midrst done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("SHR after rst", OP_SHR, 1'b1, 16'h8000, 5'd3, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b1, 4, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
